// File: rtl/intersections.sv
// rtl/intersections.sv - intersection points of two integer circles
// Iterative integer square root followed by four parallel restoring dividers.
module intersections #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] xK,
  input  logic signed [N-1:0] yK,
  input  logic signed [N-1:0] xL,
  input  logic signed [N-1:0] yL,
  input  logic [N:0]          rK,
  input  logic [N:0]          rL,
  output logic                busy,
  output logic                valid,
  output logic                no_int,
  output logic signed [N+1:0] x1P,
  output logic signed [N+1:0] y1P,
  output logic signed [N+1:0] x2P,
  output logic signed [N+1:0] y2P
);

  localparam int WS   = 4*N + 7;          // signed S and its partial products
  localparam int WA   = 2*N + 4;          // signed A
  localparam int WQ   = 4*N + 6;          // non-negative S fed to the root
  localparam int WR   = 2*N + 3;          // root
  localparam int WRM  = 2*N + 4;          // root remainder
  localparam int WN   = 3*N + 6;          // numerators and divider remainders
  localparam int WO   = N + 4;            // offset sums before saturation
  localparam int CW   = $clog2(2*N + 4);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_SQRT, S_NUM, S_DIV, S_OUT
  } state_t;

  state_t state, state_n;

  logic accept, do_prep, do_sqrt, do_num, do_div, do_out;
  logic [CW-1:0] cnt;

  logic signed [N-1:0] xk_r, yk_r, xl_r, yl_r;
  logic [N:0]          rk_r, rl_r;

  logic signed [N:0]    dx_r, dy_r;
  logic [2*N+1:0]       d2_r;
  logic signed [WA-1:0] a_r;
  logic                 deg_r;

  logic [WQ-1:0]  s_sh;
  logic [WR-1:0]  root;
  logic [WRM-1:0] rem;

  logic [WN-1:0]  div_r;
  logic [WN-1:0]  drem [4];
  logic [N+1:0]   quo  [4];
  logic           neg  [4];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_PREP;
      S_PREP: state_n = S_SQRT;
      S_SQRT: if (cnt == CW'(2*N + 2)) state_n = S_NUM;
      S_NUM:  state_n = S_DIV;
      S_DIV:  if (cnt == CW'(N + 1)) state_n = S_OUT;
      S_OUT:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    accept  = (state == S_IDLE) && start;
    do_prep = (state == S_PREP);
    do_sqrt = (state == S_SQRT);
    do_num  = (state == S_NUM);
    do_div  = (state == S_DIV);
    do_out  = (state == S_OUT);
  end

  // ---------------------------------------------------------------- PREP math
  logic signed [WS-1:0] dx_c, dy_c, d2_c, rk2_c, rl2_c, s_c;
  logic signed [WA-1:0] a_c;
  logic                 deg_c;

  always_comb begin
    dx_c  = WS'(xl_r) - WS'(xk_r);
    dy_c  = WS'(yl_r) - WS'(yk_r);
    d2_c  = dx_c*dx_c + dy_c*dy_c;
    rk2_c = WS'($signed({1'b0, rk_r})) * WS'($signed({1'b0, rk_r}));
    rl2_c = WS'($signed({1'b0, rl_r})) * WS'($signed({1'b0, rl_r}));
    a_c   = WA'(rk2_c - rl2_c + d2_c);
    s_c   = ((rk2_c * d2_c) <<< 2) - WS'(a_c) * WS'(a_c);
    deg_c = (d2_c == '0) || s_c[WS-1];
  end

  // ---------------------------------------------------------------- root step
  logic [WRM+1:0] rem_n, trial;

  always_comb begin
    rem_n = {rem, s_sh[WQ-1:WQ-2]};
    trial = {1'b0, root, 2'b01};
  end

  // ---------------------------------------------------------------- numerators
  logic signed [WN-1:0] a_n, dx_n, dy_n, r_n;
  logic signed [WN-1:0] num_c [4];

  always_comb begin
    a_n  = WN'(a_r);
    dx_n = WN'(dx_r);
    dy_n = WN'(dy_r);
    r_n  = WN'($signed({1'b0, root}));
    num_c[0] = a_n*dx_n - dy_n*r_n;
    num_c[1] = a_n*dy_n + dx_n*r_n;
    num_c[2] = a_n*dx_n + dy_n*r_n;
    num_c[3] = a_n*dy_n - dx_n*r_n;
  end

  // ---------------------------------------------------------------- offsets and saturation
  logic signed [WO-1:0] off_c [4];
  logic signed [WO-1:0] sum_c [4];
  logic signed [N+1:0]  pt_c  [4];
  localparam logic signed [WO-1:0] PMAX = WO'(2**(N+1) - 1);
  localparam logic signed [WO-1:0] PMIN = WO'(-(2**(N+1)));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      off_c[k] = $signed({2'b00, quo[k]});
      if (neg[k]) off_c[k] = -off_c[k];
      sum_c[k] = ((k % 2) == 0) ? WO'(xk_r) + off_c[k] : WO'(yk_r) + off_c[k];
      if (sum_c[k] > PMAX)      pt_c[k] = {1'b0, {(N+1){1'b1}}};
      else if (sum_c[k] < PMIN) pt_c[k] = {1'b1, {(N+1){1'b0}}};
      else                      pt_c[k] = sum_c[k][N+1:0];
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xk_r <= '0; yk_r <= '0; xl_r <= '0; yl_r <= '0;
      rk_r <= '0; rl_r <= '0;
      dx_r <= '0; dy_r <= '0; d2_r <= '0; a_r <= '0; deg_r <= 1'b0;
      s_sh <= '0; root <= '0; rem <= '0; cnt <= '0; div_r <= '0;
      for (int k = 0; k < 4; k++) begin
        drem[k] <= '0;
        quo[k]  <= '0;
        neg[k]  <= 1'b0;
      end
      valid <= 1'b0; no_int <= 1'b0;
      x1P <= '0; y1P <= '0; x2P <= '0; y2P <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        xk_r <= xK; yk_r <= yK; xl_r <= xL; yl_r <= yL;
        rk_r <= rK; rl_r <= rL;
      end
      if (do_prep) begin
        dx_r  <= dx_c[N:0];
        dy_r  <= dy_c[N:0];
        d2_r  <= d2_c[2*N+1:0];
        a_r   <= a_c;
        deg_r <= deg_c;
        // degenerate inputs still run the full schedule, on a zero radicand
        s_sh  <= deg_c ? '0 : s_c[WQ-1:0];
        root  <= '0;
        rem   <= '0;
        cnt   <= '0;
      end
      if (do_sqrt) begin
        s_sh <= {s_sh[WQ-3:0], 2'b00};
        if (rem_n >= trial) begin
          rem  <= WRM'(rem_n - trial);
          root <= {root[WR-2:0], 1'b1};
        end else begin
          rem  <= WRM'(rem_n);
          root <= {root[WR-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
      end
      if (do_num) begin
        for (int k = 0; k < 4; k++) begin
          neg[k]  <= num_c[k][WN-1];
          drem[k] <= num_c[k][WN-1] ? -num_c[k] : num_c[k];
          quo[k]  <= '0;
        end
        // quotients never exceed rK, so N+2 quotient bits from Q<<(N+1) down suffice
        div_r <= {{(WN-3*N-4){1'b0}}, d2_r, 1'b0, {(N+1){1'b0}}};
        cnt   <= '0;
      end
      if (do_div) begin
        for (int k = 0; k < 4; k++) begin
          if (drem[k] >= div_r) begin
            drem[k] <= drem[k] - div_r;
            quo[k]  <= {quo[k][N:0], 1'b1};
          end else begin
            quo[k]  <= {quo[k][N:0], 1'b0};
          end
        end
        div_r <= div_r >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (do_out) begin
        valid  <= 1'b1;
        no_int <= deg_r;
        x1P    <= deg_r ? '0 : pt_c[0];
        y1P    <= deg_r ? '0 : pt_c[1];
        x2P    <= deg_r ? '0 : pt_c[2];
        y2P    <= deg_r ? '0 : pt_c[3];
      end
    end
  end

endmodule

// File: tb/tb_intersections.sv
// tb/tb_intersections.sv - self-checking bench for intersections
// Directed and random circle pairs against a plain-arithmetic geometric model.
module tb_intersections;

  localparam int N   = 8;
  localparam int LAT = 3*N + 8;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [N-1:0] xK, yK, xL, yL;
  logic [N:0]          rK, rL;
  logic                busy, valid, no_int;
  logic signed [N+1:0] x1P, y1P, x2P, y2P;

  int checks = 0;
  int errors = 0;

  intersections #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .xK(xK), .yK(yK), .xL(xL), .yL(yL), .rK(rK), .rL(rL),
    .busy(busy), .valid(valid), .no_int(no_int),
    .x1P(x1P), .y1P(y1P), .x2P(x2P), .y2P(y2P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi = (64'sd1 <<< (N+1)) - 1;
    longint lo = -(64'sd1 <<< (N+1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Geometry straight from the circle equations; '/' on longint truncates toward zero.
  task automatic model(input int xk, yk, xl, yl, rk, rl,
                       output longint ex1, ey1, ex2, ey2, output longint enoint);
    longint dx, dy, d2, a, s, r, q;
    dx = longint'(xl - xk);
    dy = longint'(yl - yk);
    d2 = dx*dx + dy*dy;
    a  = longint'(rk)*rk - longint'(rl)*rl + d2;
    s  = 4*longint'(rk)*rk*d2 - a*a;
    if (d2 == 0 || s < 0) begin
      ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0; enoint = 1;
    end else begin
      r = longint'($sqrt(real'(s)));
      while (r*r > s) r--;
      while ((r+1)*(r+1) <= s) r++;
      q   = 2*d2;
      ex1 = sat(xk + (a*dx - dy*r)/q);
      ey1 = sat(yk + (a*dy + dx*r)/q);
      ex2 = sat(xk + (a*dx + dy*r)/q);
      ey2 = sat(yk + (a*dy - dx*r)/q);
      enoint = 0;
    end
  endtask

  task automatic drive(input int xk, yk, xl, yl, rk, rl);
    xK = N'(xk); yK = N'(yk); xL = N'(xl); yL = N'(yl);
    rK = (N+1)'(rk); rL = (N+1)'(rl);
  endtask

  task automatic do_op(input int xk, yk, xl, yl, rk, rl, input string tag);
    longint ex1, ey1, ex2, ey2, en;
    longint hx1;
    int lat;
    model(xk, yk, xl, yl, rk, rl, ex1, ey1, ex2, ey2, en);
    @(negedge clk);
    drive(xk, yk, xl, yl, rk, rl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    chk({tag, ".busy"}, busy, 1);
    while (!valid && lat < LAT + 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".no_int"}, no_int, en);
    chk({tag, ".x1P"}, x1P, ex1);
    chk({tag, ".y1P"}, y1P, ey1);
    chk({tag, ".x2P"}, x2P, ex2);
    chk({tag, ".y2P"}, y2P, ey2);
    hx1 = x1P;
    @(negedge clk);
    chk({tag, ".pulse"}, valid, 0);
    chk({tag, ".hold"}, x1P, hx1);
  endtask

  initial begin
    int pulses, first_lat, lat, xk, yk, xl, yl, rk, rl;
    rst = 1'b1; start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.valid", valid, 0);
    chk("reset.no_int", no_int, 0);
    chk("reset.x1P", x1P, 0);
    chk("reset.y2P", y2P, 0);
    rst = 1'b0;

    do_op(-16, -111, 109, -99, 236, 183, "case1");
    chk("case1.x1P_const", x1P, 117);
    chk("case1.y2P_const", y2P, -276);
    do_op(0, 0, 6, 0, 5, 5, "case345");
    chk("case345.y1P_const", y1P, 4);
    do_op(0, 0, 20, 0, 10, 10, "tangent");
    chk("tangent.x2P_const", x2P, 10);
    do_op(0, 0, 100, 0, 5, 5, "disjoint");
    chk("disjoint.no_int_const", no_int, 1);
    do_op(3, 3, 3, 3, 7, 7, "concentric");
    do_op(-128, -128, 127, 127, 511, 511, "extreme");

    for (int i = 0; i < 40; i++) begin
      xk = int'($urandom_range(0, 255)) - 128;
      yk = int'($urandom_range(0, 255)) - 128;
      xl = int'($urandom_range(0, 255)) - 128;
      yl = int'($urandom_range(0, 255)) - 128;
      rk = int'($urandom_range(0, 511));
      rl = int'($urandom_range(0, 511));
      do_op(xk, yk, xl, yl, rk, rl, $sformatf("rand%0d", i));
    end

    // start held high across the whole operation
    @(negedge clk);
    drive(0, 0, 6, 0, 5, 5);
    start = 1'b1;
    @(negedge clk);
    lat = 0; pulses = 0; first_lat = -1;
    while (lat < LAT) begin
      @(negedge clk);
      lat++;
      if (valid) begin
        pulses++;
        if (first_lat < 0) first_lat = lat;
      end
    end
    start = 1'b0;
    chk("held.pulses", pulses, 1);
    chk("held.latency", first_lat, LAT);
    chk("held.x1P", x1P, 3);
    @(negedge clk);
    chk("held.idle_after", busy, 0);

    // reset while the root is being extracted
    do_op(-16, -111, 109, -99, 236, 183, "pre_rst");
    @(negedge clk);
    drive(0, 0, 6, 0, 5, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", busy, 0);
    chk("midrst.valid", valid, 0);
    chk("midrst.x1P", x1P, 0);
    chk("midrst.y2P", y2P, 0);
    pulses = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("midrst.discarded", pulses, 0);
    do_op(0, 0, 6, 0, 5, 5, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersections.md
Name: intersections

Overview:
- Computes the two intersection points of circle K (centre xK,yK; radius rK) and circle L (centre xL,yL; radius rL) on an integer grid.
- Serves as the geometric core of the trilateration/localisation datapath.
- Multi-cycle, one result per start; built from an iterative integer square root and four parallel restoring dividers.

Parameters:
- N, 8, coordinate width in bits; radii are N+1 bits and outputs are N+2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- xK, yK, xL, yL  in  N  signed two's-complement centre coordinates.
- rK, rL  in  N+1  unsigned radii.
- busy  out  1  high from the cycle after start is accepted until valid.
- valid  out  1  one-cycle pulse; results are stable from this cycle until the next accepted start.
- no_int  out  1  no usable intersection; qualified by valid.
- x1P, y1P, x2P, y2P  out  N+2  signed intersection points.

Behaviour:
- Reset: busy, valid, no_int and all point outputs are 0. State returns to IDLE. Reset mid-operation aborts the computation and discards the result.
- start in IDLE registers all inputs. start while busy is ignored.
- Datapath sizing: every internal quantity is sized so no overflow occurs for any input.
- Math on the registered values:
  - dx = xL-xK, dy = yL-yK (N+1 signed).
  - D2 = dx²+dy².
  - A = rK² - rL² + D2 (signed).
  - S = 4·rK²·D2 - A².
- States and durations:
  - PREP: 1 cycle; computes dx, dy, D2, A, S.
  - SQRT: 2N+3 cycles; R = floor(sqrt(S)), bit-serial, one result bit per cycle.
  - NUM: 1 cycle; computes the four numerators.
  - DIV: N+2 cycles; four parallel restoring dividers.
  - OUT: 1 cycle; adds offsets, saturates, registers outputs and pulses valid.
- Latency: valid is asserted exactly 3N+8 cycles after the start-accept edge (32 for N=8).
- Degenerate cases: if D2==0 or S<0, set no_int=1, force all points to 0, and keep the same latency.
- Offset formulas, with Q = 2·D2:
  - x1 = xK + (A·dx - dy·R)/Q
  - y1 = yK + (A·dy + dx·R)/Q
  - x2 = xK + (A·dx + dy·R)/Q
  - y2 = yK + (A·dy - dx·R)/Q
- Division truncates toward zero: divide the magnitude and re-apply the sign.
- Each sum saturates to the signed N+2 range [-2^(N+1), 2^(N+1)-1].
- Tangent case (S=0): both points are identical and no_int=0.
- Point 1 lies to the left of the directed line K→L; point 2 lies to the right.
- The next start may be accepted in the cycle after valid (IDLE).

Test Plan:
- N=8, xK=-16, yK=-111, xL=109, yL=-99, rK=236, rL=183, start pulse:
  - valid at cycle 32, no_int=0.
  - Internally D2=15769, A=37976, R=45507.
  - Outputs: x1P=117, y1P=83, x2P=151, y2P=-276.
- xK=0, yK=0, rK=5, xL=6, yL=0, rL=5 → R=48; (x1P,y1P)=(3,4), (x2P,y2P)=(3,-4), no_int=0.
- Tangent: K=(0,0), rK=10, L=(20,0), rL=10 → S=0; both points (10,0), no_int=0.
- Disjoint: K=(0,0), rK=5, L=100,0, rL=5 → no_int=1, all points 0, valid still at cycle 3N+8.
  - Concentric variant K=L=(3,3) also gives no_int=1.
- Control:
  - start held high across busy → only one valid pulse per accepted start.
  - rst asserted mid-SQRT → next cycle busy=0, outputs 0.
  - A fresh start then completes normally with the full latency.
